aidma_rd_sched: RTL and testbench

// Read-command scheduler for the AIDMA AXI3 master read channels (AR/R).

---
 rtl/aidma_rd_sched.sv | 182 ++++++++++++++++++
 tb/tb_aidma_rd_sched.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidma_rd_sched.sv
// Read-command scheduler for the AIDMA AXI3 read channels.
// Splits one (address, beat count) command into INCR bursts of at most 16 beats that never
// cross a 4KB boundary, keeps at most MAX_OUT bursts in flight and streams R data onward.
module aidma_rd_sched #(
  parameter int unsigned LEN_W    = 20,
  parameter int unsigned MAX_OUT  = 4,
  parameter logic [7:0]  ARID_VAL = 8'h00
) (
  input  logic             acr_clk,
  input  logic             acr_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_beats,
  output logic [7:0]       axi_arid,
  output logic [31:0]      axi_araddr,
  output logic [3:0]       axi_arlen,
  output logic [2:0]       axi_arsize,
  output logic [1:0]       axi_arburst,
  output logic             axi_arlock,
  output logic [3:0]       axi_arcache,
  output logic [2:0]       axi_arprot,
  output logic             axi_arvalid,
  input  logic             axi_arready,
  input  logic [7:0]       axi_rid,
  input  logic [63:0]      axi_rdata,
  input  logic [1:0]       axi_rresp,
  input  logic             axi_rlast,
  input  logic             axi_rvalid,
  output logic             axi_rready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             done,
  output logic             err
);

  localparam logic [3:0] MaxOut = 4'(MAX_OUT);

  // StDone is the single done-pulse cycle, shared by zero-length and normal transfers.
  typedef enum logic [1:0] {StIdle, StDone, StIssue, StDrain} state_e;

  state_e           state_q;
  logic [31:0]      addr_q;           // start address of the next burst not yet accepted
  logic [LEN_W-1:0] rem_q;            // beats not yet covered by an accepted AR
  logic [3:0]       out_cnt_q;
  logic [3:0]       out_cnt_d;
  logic [LEN_W-1:0] bursts_issued_q;
  logic [LEN_W-1:0] bursts_done_q;

  logic             busy;
  logic             ar_hs;
  logic             r_hs;
  logic             r_last_hs;
  logic             out_dec;
  logic [4:0]       cur_n;
  logic [4:0]       nx_n;
  logic [31:0]      addr_nx;
  logic [LEN_W-1:0] rem_nx;

  // Burst size: min(remaining, 16, beats left before the next 4KB boundary).
  function automatic logic [4:0] burst_len(input logic [8:0] blk, input logic [LEN_W-1:0] rem);
    logic [9:0] room;
    logic [4:0] n;
    room = 10'd512 - {1'b0, blk};
    n    = 5'd16;
    if (room < 10'd16) n = room[4:0];
    if (rem < LEN_W'(n)) n = rem[4:0];
    return n;
  endfunction

  assign axi_arid    = ARID_VAL;
  assign axi_arsize  = 3'b011;
  assign axi_arburst = 2'b01;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = 4'b0011;
  assign axi_arprot  = 3'b000;

  assign busy       = (state_q == StIssue) || (state_q == StDrain);
  assign axi_rready = out_ready & busy;
  assign out_valid  = axi_rvalid & busy;
  assign out_data   = axi_rdata;
  assign out_last   = busy & axi_rlast & (rem_q == '0) &
                      (bursts_done_q == bursts_issued_q - LEN_W'(1));

  assign ar_hs     = axi_arvalid & axi_arready;
  assign r_hs      = axi_rvalid & axi_rready;
  assign r_last_hs = r_hs & axi_rlast;
  // Stray rlast after a mid-transfer reset must not wrap the counter.
  assign out_dec   = r_last_hs & (out_cnt_q != 4'd0);

  // Pointer advance on AR accept, size of the following burst, outstanding count update.
  always_comb begin
    cur_n   = burst_len(addr_q[11:3], rem_q);
    addr_nx = addr_q;
    rem_nx  = rem_q;
    if (ar_hs) begin
      addr_nx = addr_q + {24'd0, cur_n, 3'b000};
      rem_nx  = rem_q - LEN_W'(cur_n);
    end
    nx_n      = burst_len(addr_nx[11:3], rem_nx);
    out_cnt_d = out_cnt_q;
    if (ar_hs && !out_dec) begin
      out_cnt_d = out_cnt_q + 4'd1;
    end else if (!ar_hs && out_dec) begin
      out_cnt_d = out_cnt_q - 4'd1;
    end
  end

  // Control FSM with registered AR, handshake and status outputs.
  always_ff @(posedge acr_clk) begin
    if (acr_rst) begin
      state_q         <= StIdle;
      cmd_ready       <= 1'b1;
      axi_arvalid     <= 1'b0;
      axi_araddr      <= 32'd0;
      axi_arlen       <= 4'd0;
      done            <= 1'b0;
      err             <= 1'b0;
      addr_q          <= 32'd0;
      rem_q           <= '0;
      out_cnt_q       <= 4'd0;
      bursts_issued_q <= '0;
      bursts_done_q   <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
      done      <= 1'b0;
      if (ar_hs) bursts_issued_q <= bursts_issued_q + LEN_W'(1);
      if (r_last_hs) bursts_done_q <= bursts_done_q + LEN_W'(1);
      if (r_hs && ((axi_rresp != 2'b00) || (axi_rid != ARID_VAL))) err <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready       <= 1'b0;
            err             <= 1'b0;
            addr_q          <= cmd_addr & 32'hFFFF_FFF8;
            rem_q           <= cmd_beats;
            bursts_issued_q <= '0;
            bursts_done_q   <= '0;
            if (cmd_beats == '0) begin
              done    <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StDone: begin
          cmd_ready <= 1'b1;
          state_q   <= StIdle;
        end
        StIssue: begin
          addr_q <= addr_nx;
          rem_q  <= rem_nx;
          if (rem_nx == '0) begin
            axi_arvalid <= 1'b0;
            state_q     <= StDrain;
          end else if (!axi_arvalid || ar_hs) begin
            // A held request keeps address/length stable until accepted.
            if (out_cnt_d < MaxOut) begin
              axi_arvalid <= 1'b1;
              axi_araddr  <= addr_nx;
              axi_arlen   <= 4'(nx_n - 5'd1);
            end else begin
              axi_arvalid <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (out_cnt_d == 4'd0) begin
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aidma_rd_sched.sv
// Directed bench for aidma_rd_sched: behavioural burst planner, AXI read slave and a
// per-cycle compare process, plus literal expectations for the reference transfers.
module tb_aidma_rd_sched;

  localparam int          LEN_W    = 20;
  localparam int          MAX_OUT  = 4;
  localparam logic [7:0]  ARID_VAL = 8'h00;

  logic             acr_clk = 1'b0;
  logic             acr_rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_addr = 32'd0;
  logic [LEN_W-1:0] cmd_beats = '0;
  logic [7:0]       axi_arid;
  logic [31:0]      axi_araddr;
  logic [3:0]       axi_arlen;
  logic [2:0]       axi_arsize;
  logic [1:0]       axi_arburst;
  logic             axi_arlock;
  logic [3:0]       axi_arcache;
  logic [2:0]       axi_arprot;
  logic             axi_arvalid;
  logic             axi_arready = 1'b0;
  logic [7:0]       axi_rid = 8'h00;
  logic [63:0]      axi_rdata = 64'd0;
  logic [1:0]       axi_rresp = 2'b00;
  logic             axi_rlast = 1'b0;
  logic             axi_rvalid = 1'b0;
  logic             axi_rready;
  logic             out_valid;
  logic [63:0]      out_data;
  logic             out_last;
  logic             out_ready = 1'b0;
  logic             done;
  logic             err;

  always #5 acr_clk = ~acr_clk;

  aidma_rd_sched #(
    .LEN_W    (LEN_W),
    .MAX_OUT  (MAX_OUT),
    .ARID_VAL (ARID_VAL)
  ) dut (
    .acr_clk     (acr_clk),
    .acr_rst     (acr_rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_beats   (cmd_beats),
    .axi_arid    (axi_arid),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arlock  (axi_arlock),
    .axi_arcache (axi_arcache),
    .axi_arprot  (axi_arprot),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rid     (axi_rid),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rlast   (axi_rlast),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .done        (done),
    .err         (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [63:0] beat_data(input int k);
    return {32'hA5A5_0000 + 32'(k), ~32'(k)};
  endfunction

  // ---------------- model state ----------------
  int          phase = 0;          // 0 idle, 1 transferring, 2 done-pulse cycle
  logic        done_exp = 1'b0;
  logic        err_m = 1'b0;
  logic        chk_en = 1'b0;
  int          exp_beats = 0;
  int          beats_seen = 0;
  int          out_total = 0;
  int          outst = 0;
  int          last_beat_idx = -1;
  logic [31:0] exp_addr_q[$];
  logic [3:0]  exp_len_q[$];
  logic [31:0] ar_log_addr[$];
  logic [3:0]  ar_log_len[$];
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = 32'd0;
  logic [3:0]  prev_len = 4'd0;

  // handshake snapshots handed to the slave
  logic        ar_hs_s = 1'b0;
  logic        r_hs_s = 1'b0;
  logic        rst_s = 1'b0;
  logic [3:0]  arlen_s = 4'd0;

  // slave knobs
  logic        r_en = 1'b0;
  int          ready_mode = 0;
  int          bad_resp_beat = -1;
  int          bad_id_beat = -1;

  // Expected burst list from the splitting rules, plain arithmetic.
  task automatic plan(input logic [31:0] addr, input int beats);
    int unsigned a;
    int rem;
    int n;
    int room;
    a   = addr & 32'hFFFF_FFF8;
    rem = beats;
    exp_addr_q.delete();
    exp_len_q.delete();
    while (rem > 0) begin
      n    = 16;
      room = (4096 - int'(a % 4096)) / 8;
      if (room < n) n = room;
      if (rem < n) n = rem;
      exp_addr_q.push_back(a);
      exp_len_q.push_back(4'(n - 1));
      a   = a + n * 8;
      rem = rem - n;
    end
  endtask

  // Compare process: mid-cycle sampling, then model advance for the coming edge.
  always @(negedge acr_clk) begin
    int  nxt_phase;
    logic nxt_err;
    logic last_exp;
    ar_hs_s   = axi_arvalid && axi_arready;
    r_hs_s    = axi_rvalid && axi_rready;
    rst_s     = acr_rst;
    arlen_s   = axi_arlen;
    nxt_phase = phase;
    nxt_err   = err_m;
    if (chk_en) begin
      check("cmd_ready", cmd_ready, phase == 0);
      check("done", done, done_exp);
      check("err", err, err_m);
      check("rready", axi_rready, out_ready && phase == 1);
      check("out_valid", out_valid, axi_rvalid && phase == 1);
      if (phase != 1) check("arvalid_quiet", axi_arvalid, 0);
      if (axi_arvalid) check("ar_outstanding_limit", outst < MAX_OUT, 1);
      if (prev_pend) begin
        check("ar_held", axi_arvalid, 1);
        check("ar_addr_stable", axi_araddr, prev_addr);
        check("ar_len_stable", axi_arlen, prev_len);
      end
      if (ar_hs_s) begin
        check("ar_consts", {axi_arid, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot},
              {ARID_VAL, 3'b011, 2'b01, 1'b0, 4'b0011, 3'b000});
        if (exp_addr_q.size() == 0) begin
          fail_now("ar_unexpected");
        end else begin
          check("ar_addr", axi_araddr, exp_addr_q.pop_front());
          check("ar_len", axi_arlen, exp_len_q.pop_front());
        end
        ar_log_addr.push_back(axi_araddr);
        ar_log_len.push_back(axi_arlen);
        outst++;
      end
      if (r_hs_s) begin
        check("out_data", out_data, beat_data(out_total));
        out_total++;
        beats_seen++;
        last_exp = (beats_seen == exp_beats);
        check("out_last", out_last, last_exp);
        if (out_last) last_beat_idx = beats_seen;
        if (axi_rlast) outst--;
        if (axi_rresp != 2'b00 || axi_rid != ARID_VAL) nxt_err = 1'b1;
        if (last_exp) nxt_phase = 2;
      end
      if (phase == 2) nxt_phase = 0;
      if (phase == 0 && cmd_valid && !acr_rst) begin
        nxt_err    = 1'b0;
        exp_beats  = int'(cmd_beats);
        beats_seen = 0;
        last_beat_idx = -1;
        plan(cmd_addr, exp_beats);
        nxt_phase  = (exp_beats == 0) ? 2 : 1;
      end
      prev_pend = axi_arvalid && !axi_arready;
      prev_addr = axi_araddr;
      prev_len  = axi_arlen;
    end
    phase    = nxt_phase;
    err_m    = nxt_err;
    done_exp = (nxt_phase == 2);
    if (acr_rst) begin
      phase     = 0;
      err_m     = 1'b0;
      done_exp  = 1'b0;
      outst     = 0;
      prev_pend = 1'b0;
      exp_addr_q.delete();
      exp_len_q.delete();
      chk_en    = 1'b1;
    end
  end

  // AXI read slave and consumer: returns each accepted burst in order.
  initial begin
    int pend[$];
    int beat_in_burst = 0;
    int sent_cnt = 0;
    int cyc = 0;
    forever begin
      @(posedge acr_clk);
      #1;
      cyc++;
      if (rst_s) begin
        pend.delete();
        beat_in_burst = 0;
      end else begin
        if (r_hs_s) begin
          sent_cnt++;
          if (beat_in_burst == pend[0]) begin
            void'(pend.pop_front());
            beat_in_burst = 0;
          end else begin
            beat_in_burst++;
          end
        end
        if (ar_hs_s) pend.push_back(int'(arlen_s));
      end
      out_ready = (ready_mode == 0) ? 1'b1 : cyc[0];
      if (r_en && pend.size() > 0 && !rst_s) begin
        axi_rvalid = 1'b1;
        axi_rdata  = beat_data(sent_cnt);
        axi_rlast  = (beat_in_burst == pend[0]);
        axi_rresp  = (sent_cnt == bad_resp_beat) ? 2'b10 : 2'b00;
        axi_rid    = (sent_cnt == bad_id_beat) ? 8'h5A : ARID_VAL;
      end else begin
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rresp  = 2'b00;
        axi_rid    = ARID_VAL;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge acr_clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [LEN_W-1:0] b);
    bit ok;
    ok = 1'b0;
    step(1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_beats = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge acr_clk);
      if (cmd_ready) ok = 1'b1;
      else step(1);
    end
    step(1);
    cmd_valid = 1'b0;
    if (!ok) fail_now("cmd_accept");
  endtask

  task automatic wait_done(input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge acr_clk);
      if (done) seen = 1'b1;
    end
    if (!seen) fail_now("done_wait");
  endtask

  task automatic check_ar(input string name, input int idx, input logic [31:0] a,
                          input logic [3:0] l);
    if (idx < ar_log_addr.size()) begin
      check(name, {ar_log_addr[idx], ar_log_len[idx]}, {a, l});
    end else begin
      fail_now(name);
    end
  endtask

  initial begin
    int  base;
    bit  seen;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit seen;
    step(3);
    acr_rst = 1'b0;
    @(negedge acr_clk);
    check("rst_araddr", axi_araddr, 32'd0);
    check("rst_arlen", axi_arlen, 4'd0);
    check("rst_arvalid", axi_arvalid, 0);
    check("rst_cmd_ready", cmd_ready, 1);

    // 1: three bursts from 0x1000, 40 beats
    axi_arready = 1'b1;
    r_en = 1'b1;
    ready_mode = 0;
    base = ar_log_addr.size();
    send_cmd(32'h1000, 40);
    wait_done(2000);
    check("t1_ar_count", ar_log_addr.size() - base, 3);
    check_ar("t1_ar0", base, 32'h1000, 4'd15);
    check_ar("t1_ar1", base + 1, 32'h1080, 4'd15);
    check_ar("t1_ar2", base + 2, 32'h1100, 4'd7);
    check("t1_beats", beats_seen, 40);
    check("t1_last_idx", last_beat_idx, 40);

    // 2: 4KB boundary split, consumer backpressure
    ready_mode = 1;
    base = ar_log_addr.size();
    send_cmd(32'h1FC0, 16);
    wait_done(2000);
    check("t2_ar_count", ar_log_addr.size() - base, 2);
    check_ar("t2_ar0", base, 32'h1FC0, 4'd7);
    check_ar("t2_ar1", base + 1, 32'h2000, 4'd7);
    check("t2_beats", beats_seen, 16);

    // 3: outstanding limit with R held off
    ready_mode = 0;
    r_en = 1'b0;
    base = ar_log_addr.size();
    send_cmd(32'h0000_0000, 128);
    step(30);
    @(negedge acr_clk);
    check("t3_ar_capped", ar_log_addr.size() - base, 4);
    check("t3_arvalid_low", axi_arvalid, 0);
    r_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge acr_clk);
      if (axi_rvalid && axi_rready && axi_rlast) seen = 1'b1;
    end
    if (!seen) fail_now("t3_first_rlast");
    @(negedge acr_clk);
    check("t3_fifth_ar", axi_arvalid, 1);
    wait_done(3000);
    check("t3_ar_total", ar_log_addr.size() - base, 8);
    check("t3_beats", beats_seen, 128);

    // 4: error response on beat 5
    bad_resp_beat = out_total + 4;
    send_cmd(32'h3000, 16);
    wait_done(2000);
    check("t4_err", err, 1);
    check("t4_beats", beats_seen, 16);
    bad_resp_beat = -1;

    // 5: zero-length command clears err and pulses done
    send_cmd(32'h40, 0);
    @(negedge acr_clk);
    check("t5_done", done, 1);
    check("t5_err_clr", err, 0);
    check("t5_no_ar", axi_arvalid, 0);
    @(negedge acr_clk);
    check("t5_done_drop", done, 0);
    check("t5_cmd_ready", cmd_ready, 1);

    // 7: rid mismatch flags err
    bad_id_beat = out_total + 2;
    send_cmd(32'h3F00, 4);
    wait_done(2000);
    check("t7_err_rid", err, 1);
    bad_id_beat = -1;

    // 6: reset while an AR is stalled
    axi_arready = 1'b0;
    send_cmd(32'h5000, 64);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge acr_clk);
      if (axi_arvalid) seen = 1'b1;
    end
    if (!seen) fail_now("t6_arvalid");
    step(1);
    acr_rst = 1'b1;
    step(1);
    @(negedge acr_clk);
    check("t6_arvalid", axi_arvalid, 0);
    check("t6_cmd_ready", cmd_ready, 1);
    check("t6_err", err, 0);
    check("t6_done", done, 0);
    step(1);
    acr_rst = 1'b0;
    axi_arready = 1'b1;

    // 8: transfer straddling 0x1000 after reset
    base = ar_log_addr.size();
    send_cmd(32'h0FF8, 3);
    wait_done(2000);
    check("t8_ar_count", ar_log_addr.size() - base, 2);
    check_ar("t8_ar0", base, 32'h0FF8, 4'd0);
    check_ar("t8_ar1", base + 1, 32'h1000, 4'd1);
    check("t8_last_idx", last_beat_idx, 3);

    step(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
